// File: rtl/prbs8_pkg.sv
// Shared types and constants for the PRBS8 burst source.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
//
// Contents:
//   state_t        - burst FSM states (IDLE, BURST, GAP)
//   LFSR_TAPS      - feedback tap mask, bits 7,5,4,3
//   ZERO_SEED_SUB  - value substituted for an all-zero seed
//   lfsr_next()    - one Fibonacci shift-left step
//   seed_fix()     - maps the lockup seed 8'h00 to ZERO_SEED_SUB
package prbs8_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] ZERO_SEED_SUB = 8'h01;

  // Shift left, feedback is the XOR of the tapped bits entering at bit 0.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

  // All-zero is the one state the LFSR never leaves, so it is never loaded.
  function automatic logic [7:0] seed_fix(input logic [7:0] v);
    return (v == 8'h00) ? ZERO_SEED_SUB : v;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR register with seed load and single-step advance.
// Latency: q reflects a step or load on the clock edge after it is requested.
// Backpressure: none; the register only moves when step or load is high.
//
// Ports:
//   clk, rst  - clock and asynchronous active-high reset (q <= SEED_DFLT)
//   step      - advance one position this edge
//   load      - load load_val this edge (takes priority over step)
//   load_val  - seed value; 8'h00 is replaced by ZERO_SEED_SUB
//   q         - current LFSR value
module lfsr8
  import prbs8_pkg::*;
#(
  parameter logic [7:0] SEED_DFLT = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = seed_fix(load_val);
    end else if (step) begin
      q_d = lfsr_next(q_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= SEED_DFLT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/prbs8_src.sv
// Pseudo-random byte source emitting configurable bursts separated by idle gaps.
// Latency: first beat is presented the cycle after i_en is seen in IDLE.
// Backpressure: valid/ready; o_data holds and the LFSR stalls while i_ready=0.
//
// Ports:
//   clk, rst     - clock and asynchronous active-high reset
//   i_en         - request bursts; sampled at burst boundaries only
//   i_seed_ld    - load i_seed into the LFSR (acted on in IDLE only)
//   i_seed       - LFSR seed
//   i_burst_len  - beats per burst minus one, latched at burst start
//   i_gap_len    - idle cycles between bursts, latched at burst start
//   i_ready      - downstream ready
//   o_valid      - o_data valid (BURST state)
//   o_data       - current LFSR value
//   o_busy       - FSM is in BURST or GAP
//   o_beats      - free-running count of accepted beats (wraps)
module prbs8_src
  import prbs8_pkg::*;
#(
  parameter logic [7:0] SEED_DFLT = 8'h01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_seed_ld,
  input  logic [7:0]  i_seed,
  input  logic [3:0]  i_burst_len,
  input  logic [3:0]  i_gap_len,
  input  logic        i_ready,
  output logic        o_valid,
  output logic [7:0]  o_data,
  output logic        o_busy,
  output logic [15:0] o_beats
);

  state_t      state_q, state_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic [15:0] beats_q, beats_d;
  logic [3:0]  beat_cnt_q, beat_cnt_d;  // index of the beat being presented
  logic [3:0]  gap_cnt_q, gap_cnt_d;    // gap cycles remaining, including this one
  logic [3:0]  burst_len_q, burst_len_d;
  logic [3:0]  gap_len_q, gap_len_d;

  logic        accept;
  logic        start_burst;
  logic        lfsr_step;
  logic        lfsr_load;
  logic [7:0]  lfsr_q;

  // valid_q is high exactly when the FSM is in BURST, so it doubles as the
  // state qualifier for a handshake.
  assign accept = valid_q & i_ready;

  lfsr8 #(
    .SEED_DFLT (SEED_DFLT)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .step     (lfsr_step),
    .load     (lfsr_load),
    .load_val (i_seed),
    .q        (lfsr_q)
  );

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    burst_len_d = burst_len_q;
    gap_len_d   = gap_len_q;
    start_burst = 1'b0;
    lfsr_step   = 1'b0;
    lfsr_load   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A seed load and a burst start may share an edge; the loaded
        // value is then the first beat presented.
        lfsr_load   = i_seed_ld;
        start_burst = i_en;
      end

      ST_BURST: begin
        if (accept) begin
          lfsr_step = 1'b1;
          if (beat_cnt_q == burst_len_q) begin
            // Last beat of the burst: i_en is only consulted here, so a
            // mid-burst drop of i_en never truncates the burst.
            beat_cnt_d = 4'd0;
            if (gap_len_q != 4'd0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_len_q;
            end else if (i_en) begin
              start_burst = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
          end
        end
      end

      ST_GAP: begin
        if (gap_cnt_q <= 4'd1) begin
          gap_cnt_d = 4'd0;
          if (i_en) begin
            start_burst = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Every burst entry re-samples the length inputs.
    if (start_burst) begin
      state_d     = ST_BURST;
      beat_cnt_d  = 4'd0;
      burst_len_d = i_burst_len;
      gap_len_d   = i_gap_len;
    end

    beats_d = accept ? (beats_q + 16'd1) : beats_q;

    // Outputs are registered from the next state so they line up with it.
    valid_d = (state_d == ST_BURST);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      beats_q     <= 16'd0;
      beat_cnt_q  <= 4'd0;
      gap_cnt_q   <= 4'd0;
      burst_len_q <= 4'd0;
      gap_len_q   <= 4'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      beats_q     <= beats_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      burst_len_q <= burst_len_d;
      gap_len_q   <= gap_len_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = lfsr_q;
  assign o_busy  = busy_q;
  assign o_beats = beats_q;

endmodule

// File: tb/tb_prbs8_src.sv
// Directed bench for prbs8_src: a per-cycle vector table, then long-run,
// wrap and asynchronous-reset sequences.
module tb_prbs8_src;

  logic        clk;
  logic        rst;
  logic        i_en;
  logic        i_seed_ld;
  logic [7:0]  i_seed;
  logic [3:0]  i_burst_len;
  logic [3:0]  i_gap_len;
  logic        i_ready;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_busy;
  logic [15:0] o_beats;

  int n_vec;
  int n_err;

  prbs8_src #(.SEED_DFLT(8'h01)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_en        (i_en),
    .i_seed_ld   (i_seed_ld),
    .i_seed      (i_seed),
    .i_burst_len (i_burst_len),
    .i_gap_len   (i_gap_len),
    .i_ready     (i_ready),
    .o_valid     (o_valid),
    .o_data      (o_data),
    .o_busy      (o_busy),
    .o_beats     (o_beats)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        sld;
    logic [7:0]  seed;
    logic [3:0]  bl;
    logic [3:0]  gl;
    logic        rdy;
    logic        ev;
    logic [7:0]  ed;
    logic        eb;
    logic [15:0] ebt;
  } vec_t;

  localparam int NVEC  = 24;
  localparam int NLONG = 65530;

  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic en, input logic sld, input logic [7:0] seed,
                              input logic [3:0] bl, input logic [3:0] gl, input logic rdy,
                              input logic ev, input logic [7:0] ed, input logic eb,
                              input logic [15:0] ebt);
    vec_t v;
    v.en = en; v.sld = sld; v.seed = seed; v.bl = bl; v.gl = gl; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.eb = eb; v.ebt = ebt;
    return v;
  endfunction

  // Reference step written directly from the polynomial.
  function automatic logic [7:0] model_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic cmp(input string nm, input logic ev, input logic [7:0] ed,
                     input logic eb, input logic [15:0] ebt);
    n_vec++;
    if (o_valid !== ev || o_data !== ed || o_busy !== eb || o_beats !== ebt) begin
      n_err++;
      $display("FAIL %s: got valid=%0b data=%02h busy=%0b beats=%04h, want valid=%0b data=%02h busy=%0b beats=%04h",
               nm, o_valid, o_data, o_busy, o_beats, ev, ed, eb, ebt);
    end
  endtask

  task automatic cmp_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic en, input logic sld, input logic [7:0] seed,
                       input logic [3:0] bl, input logic [3:0] gl, input logic rdy);
    i_en = en; i_seed_ld = sld; i_seed = seed;
    i_burst_len = bl; i_gap_len = gl; i_ready = rdy;
  endtask

  initial begin
    logic [7:0]  exp_d;
    logic [15:0] exp_n;
    int bub, bad_d, zero_d, bad_n;

    n_vec = 0;
    n_err = 0;

    // Each row: inputs applied before an edge, outputs expected after it.
    // 4-beat bursts with a 2-cycle gap, then a 3-cycle stall mid-burst.
    tbl[0]  = mk(1,0,8'h00,4'd3,4'd2,1, 1,8'h01,1,16'd0);
    tbl[1]  = mk(1,0,8'h00,4'd3,4'd2,1, 1,8'h02,1,16'd1);
    tbl[2]  = mk(1,0,8'h00,4'd3,4'd2,1, 1,8'h04,1,16'd2);
    tbl[3]  = mk(1,0,8'h00,4'd3,4'd2,1, 1,8'h08,1,16'd3);
    tbl[4]  = mk(1,0,8'h00,4'd3,4'd2,1, 0,8'h11,1,16'd4);
    tbl[5]  = mk(1,0,8'h00,4'd3,4'd2,1, 0,8'h11,1,16'd4);
    tbl[6]  = mk(1,0,8'h00,4'd3,4'd2,1, 1,8'h11,1,16'd4);
    tbl[7]  = mk(1,0,8'h00,4'd3,4'd2,1, 1,8'h23,1,16'd5);
    tbl[8]  = mk(1,0,8'h00,4'd3,4'd2,0, 1,8'h23,1,16'd5);
    tbl[9]  = mk(1,0,8'h00,4'd3,4'd2,0, 1,8'h23,1,16'd5);
    tbl[10] = mk(1,0,8'h00,4'd3,4'd2,0, 1,8'h23,1,16'd5);
    tbl[11] = mk(1,0,8'h00,4'd3,4'd2,1, 1,8'h47,1,16'd6);
    tbl[12] = mk(1,0,8'h00,4'd3,4'd2,1, 1,8'h8E,1,16'd7);
    // i_en dropped on the last beat: gap still runs, then IDLE.
    tbl[13] = mk(0,0,8'h00,4'd3,4'd2,1, 0,8'h1C,1,16'd8);
    tbl[14] = mk(0,0,8'h00,4'd3,4'd2,1, 0,8'h1C,1,16'd8);
    tbl[15] = mk(0,0,8'h00,4'd3,4'd2,1, 0,8'h1C,0,16'd8);
    tbl[16] = mk(0,0,8'h00,4'd3,4'd2,1, 0,8'h1C,0,16'd8);
    // Zero seed substitutes 01; single-beat burst back to IDLE.
    tbl[17] = mk(1,1,8'h00,4'd0,4'd0,1, 1,8'h01,1,16'd8);
    tbl[18] = mk(0,0,8'h00,4'd0,4'd0,1, 0,8'h02,0,16'd9);
    // Seed 08 with start; i_en dropped after beat 1; seed load in BURST ignored.
    tbl[19] = mk(1,1,8'h08,4'd3,4'd0,1, 1,8'h08,1,16'd9);
    tbl[20] = mk(0,1,8'h55,4'd3,4'd0,1, 1,8'h11,1,16'd10);
    tbl[21] = mk(0,0,8'h00,4'd3,4'd0,1, 1,8'h23,1,16'd11);
    tbl[22] = mk(0,0,8'h00,4'd3,4'd0,1, 1,8'h47,1,16'd12);
    tbl[23] = mk(0,0,8'h00,4'd3,4'd0,1, 0,8'h8E,0,16'd13);

    // Reset state.
    rst = 1'b1;
    drive(0, 0, 8'h00, 4'd0, 4'd0, 0);
    repeat (2) @(posedge clk);
    #1;
    cmp("reset_state", 0, 8'h01, 0, 16'd0);
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(tbl[i].en, tbl[i].sld, tbl[i].seed, tbl[i].bl, tbl[i].gl, tbl[i].rdy);
      @(posedge clk);
      #1;
      cmp($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].eb, tbl[i].ebt);
    end

    // Long run of back-to-back 16-beat bursts from seed 01: period, no zero,
    // no bubble between bursts, beat counter wrap.
    drive(1, 1, 8'h01, 4'd15, 4'd0, 1);
    @(posedge clk);
    #1;
    cmp("long_start", 1, 8'h01, 1, 16'd13);
    i_seed_ld = 1'b0;
    exp_d = 8'h01;
    exp_n = 16'd13;
    bub = 0; bad_d = 0; zero_d = 0; bad_n = 0;
    for (int k = 0; k < NLONG; k++) begin
      if (o_valid !== 1'b1) bub++;
      if (o_data !== exp_d) bad_d++;
      if (o_data === 8'h00) zero_d++;
      if (o_beats !== exp_n) bad_n++;
      if (k == 255) cmp_val("beat256_is_01", {24'd0, o_data}, 32'h01);
      if (exp_n == 16'hFFFF) cmp_val("beats_ffff", {16'd0, o_beats}, 32'hFFFF);
      if (exp_n == 16'h0000) cmp_val("beats_wrap", {16'd0, o_beats}, 32'h0000);
      @(posedge clk);
      #1;
      exp_d = model_next(exp_d);
      exp_n = exp_n + 16'd1;
    end
    cmp_val("long_no_bubble", bub, 0);
    cmp_val("long_data_seq", bad_d, 0);
    cmp_val("long_no_zero", zero_d, 0);
    cmp_val("long_beat_cnt", bad_n, 0);

    // Asynchronous reset mid-burst, between clock edges.
    #2;
    rst = 1'b1;
    #1;
    cmp("async_rst", 0, 8'h01, 0, 16'd0);
    @(posedge clk);
    #1;
    cmp("rst_held", 0, 8'h01, 0, 16'd0);
    rst = 1'b0;
    drive(1, 0, 8'h00, 4'd1, 4'd0, 1);
    @(posedge clk);
    #1;
    cmp("post_rst_b0", 1, 8'h01, 1, 16'd0);
    drive(0, 0, 8'h00, 4'd1, 4'd0, 1);
    @(posedge clk);
    #1;
    cmp("post_rst_b1", 1, 8'h02, 1, 16'd1);
    @(posedge clk);
    #1;
    cmp("post_rst_idle", 0, 8'h04, 0, 16'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prbs8_src.md
PRBS8_SRC -- requirements
Module: prbs8_src

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, ports named clk and rst.
REQ-002 Port list (name, direction, width, meaning), clock and reset first:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- i_en  in  1  enable burst generation
- i_seed_ld  in  1  seed load strobe
- i_seed  in  8  LFSR seed value
- i_burst_len  in  4  beats per burst, minus 1
- i_gap_len  in  4  idle cycles between bursts
- i_ready  in  1  downstream ready
- o_valid  out  1  o_data valid
- o_data  out  8  pseudo-random byte, the downstream i_data stream
- o_busy  out  1  FSM not in IDLE
- o_beats  out  16  count of accepted beats
REQ-003 Parameter: SEED_DFLT, default 8'h01, LFSR value at reset.

Function
REQ-004 LFSR SHALL be 8-bit Fibonacci, shift-left.
- next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}
- period 255
- from 8'h01 the sequence is 01,02,04,08,11,23,47.
REQ-005 o_data SHALL always equal the LFSR register; no extra output register.
REQ-006 A beat is accepted when o_valid=1 and i_ready=1 at the same rising edge.
- The LFSR SHALL advance only on an accepted beat.
- o_data SHALL hold stable while o_valid=1 and i_ready=0.
REQ-007 FSM states: IDLE, BURST, GAP.
- o_valid=1 only in BURST.
- o_busy=1 in BURST and GAP.
REQ-008 IDLE -> BURST on the first edge with i_en=1.
- i_burst_len and i_gap_len SHALL be latched on that edge.
- Effective burst length = latched i_burst_len + 1 (1..16 beats).
REQ-009 In BURST, on the accepted last beat:
- latched gap >0: go to GAP.
- gap =0 and i_en=1: stay in BURST, re-latch lengths.
- gap =0 and i_en=0: go to IDLE.
REQ-010 GAP SHALL last exactly the latched gap cycles with o_valid=0.
- At the end of the gap: i_en=1 -> BURST (re-latch lengths); i_en=0 -> IDLE.
REQ-011 Deasserting i_en mid-burst SHALL NOT truncate the burst; the remaining beats complete first.
REQ-012 i_seed_ld SHALL be honoured only in IDLE and ignored in BURST and GAP.
- A seed of 8'h00 SHALL load 8'h01 (lockup avoidance).
- If i_seed_ld and i_en are both 1 in IDLE, the seed loads and the burst starts with the loaded value as its first beat.
REQ-013 o_beats SHALL increment on every accepted beat and wrap 16'hFFFF -> 16'h0000.

Reset
REQ-014 rst=1 SHALL asynchronously force:
- state IDLE
- LFSR = SEED_DFLT
- o_valid=0, o_busy=0, o_beats=0
- beat and gap counters = 0
REQ-015 Reset asserted mid-burst SHALL abort the burst with no pending beat; after rst falls, operation restarts from IDLE on the first i_en.

Structure
REQ-016 A shared package SHALL hold:
- the state enumeration (IDLE, BURST, GAP)
- the LFSR tap mask constant 8'hB8 (bits 7,5,4,3)
- the zero-seed substitute 8'h01
REQ-017 The LFSR register and next-state logic SHALL be one sub-module, lfsr8, with ports clk, rst, step, load, load_val, q; the FSM and counters stay in prbs8_src.

Verification
REQ-018 Reset, then i_en=1, i_burst_len=3, i_gap_len=2, i_ready=1 -> o_data 01,02,04,08 on consecutive cycles with o_valid=1, then 2 cycles o_valid=0, then 11,23,47,...
REQ-019 i_ready=0 for 3 cycles mid-burst -> o_data and o_valid held, o_beats unchanged, sequence resumes with no skipped value.
REQ-020 In IDLE, i_seed_ld=1 with i_seed=8'h00 -> first beat 8'h01; in IDLE with i_seed=8'h08 -> first beats 08,11,23; i_seed_ld during BURST -> ignored, sequence continues.
REQ-021 Drop i_en after beat 1 of a 4-beat burst -> all 4 beats delivered, then IDLE with o_busy=0; i_burst_len=15, i_gap_len=0 -> 16-beat bursts back-to-back with no bubble.
REQ-022 Run 255 accepted beats from seed 01 -> 256th beat is 01 again, no 00 ever produced; preload near wrap -> o_beats 16'hFFFF -> 16'h0000.
REQ-023 Assert rst mid-burst, asynchronously to clk -> o_valid falls without a clock edge, LFSR reads 01, and the next burst starts at 01.
